// File: rtl/core_pkg.sv
// Shared encodings for the core pipeline: result-select codes, load/store size
// codes and the MEM-stage access FSM states.
package core_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_R,
        ERR
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// Data-memory bus: single outstanding request, req/gnt handshake, rvalid return.
interface dmem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_stage_lsu_align.sv
// Byte-lane logic: store enables/replicated data, load extraction and
// extension, and alignment checking. Purely combinational.
module lsu_align
    import core_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign off      = addr_i[1:0];
    assign byte_sel = rdata_i[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = (off != 2'b00);
        // Unlisted funct3 codes fall through as full-word accesses.
        if (is_store_i) begin
            case (funct3_i)
                F3_B: begin
                    be_o       = 4'b0001 << off;
                    wdata_o    = {4{wdata_i[7:0]}};
                    misalign_o = 1'b0;
                end
                F3_H: begin
                    be_o       = off[1] ? 4'b1100 : 4'b0011;
                    wdata_o    = {2{wdata_i[15:0]}};
                    misalign_o = off[0];
                end
                default: ;
            endcase
        end else begin
            case (funct3_i)
                F3_B:  begin rdata_o = {{24{byte_sel[7]}}, byte_sel};  misalign_o = 1'b0;   end
                F3_BU: begin rdata_o = {24'h0, byte_sel};              misalign_o = 1'b0;   end
                F3_H:  begin rdata_o = {{16{half_sel[15]}}, half_sel}; misalign_o = off[0]; end
                F3_HU: begin rdata_o = {16'h0, half_sel};              misalign_o = off[0]; end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on the data bus, stalls upstream while an
// access is outstanding, and registers the MEM/WB pipeline stage.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int INST_WIDTH          = 32,
    parameter int INST_ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic [INST_WIDTH-1:0]          INST_EX_MEM_i,
    input  logic                           reg_write_EX_MEM_i,
    input  logic                           mem_write_EX_MEM_i,
    input  logic [1:0]                     result_sel_EX_MEM_i,
    input  logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_i,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_i,
    input  logic [DATA_WIDTH-1:0]          write_data_EX_MEM_i,
    input  logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_EX_MEM_i,
    input  logic [2:0]                     funct3_EX_MEM_i,
    dmem_if.master                         dmem,
    output logic                           mem_stall_o,
    output logic [INST_WIDTH-1:0]          INST_MEM_WB_o,
    output logic                           reg_write_MEM_WB_o,
    output logic [1:0]                     result_sel_MEM_WB_o,
    output logic [DATA_WIDTH-1:0]          alu_res_MEM_WB_o,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM_WB_o,
    output logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_MEM_WB_o,
    output logic [DATA_WIDTH-1:0]          read_data_MEM_WB_o,
    output logic                           misalign_o,
    output logic                           bus_err_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         bus_err_q, bus_err_d;
    logic                         misalign_q, misalign_d;
    logic [INST_WIDTH-1:0]        inst_q, inst_d;
    logic                         reg_write_q, reg_write_d;
    logic [1:0]                   result_sel_q, result_sel_d;
    logic [DATA_WIDTH-1:0]        alu_res_q, alu_res_d;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [INST_ADDR_WIDTH-1:0]   pc4_q, pc4_d;
    logic [DATA_WIDTH-1:0]        read_data_q, read_data_d;

    logic        is_store, acc, mis, req_c, stall_c, retire, ld_done;
    logic [3:0]  be;
    logic [31:0] wdata_lane, ld_ext;

    assign is_store = mem_write_EX_MEM_i;
    assign acc      = is_store | (result_sel_EX_MEM_i == RES_MEM);

    lsu_align u_align (
        .addr_i     (alu_res_EX_MEM_i),
        .funct3_i   (funct3_EX_MEM_i),
        .is_store_i (is_store),
        .wdata_i    (write_data_EX_MEM_i),
        .rdata_i    (dmem.rdata),
        .be_o       (be),
        .wdata_o    (wdata_lane),
        .rdata_o    (ld_ext),
        .misalign_o (mis)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus_err_d  = bus_err_q;
        misalign_d = 1'b0;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        retire     = 1'b0;
        ld_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && !mis) begin
                    req_c = 1'b1;
                    if (dmem.gnt) begin
                        cnt_d = '0;
                        if (is_store) begin
                            retire = 1'b1;
                        end else begin
                            state_d = WAIT_R;
                            stall_c = 1'b1;
                        end
                    end else begin
                        stall_c = 1'b1;
                        if (cnt_q == CNT_LAST) state_d = ERR;
                        else                   cnt_d   = cnt_q + 1'b1;
                    end
                end else if (acc) begin
                    misalign_d = 1'b1;
                end else begin
                    retire = 1'b1;
                end
            end
            WAIT_R: begin
                if (dmem.rvalid) begin
                    retire  = 1'b1;
                    ld_done = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == CNT_LAST) state_d = ERR;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            ERR: begin
                // Faulting instruction leaves as a bubble; upstream advances now.
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ERR) bus_err_d = 1'b1;

        inst_d       = '0;
        reg_write_d  = 1'b0;
        result_sel_d = '0;
        alu_res_d    = '0;
        rd_d         = '0;
        pc4_d        = '0;
        read_data_d  = '0;
        if (retire) begin
            inst_d       = INST_EX_MEM_i;
            reg_write_d  = reg_write_EX_MEM_i;
            result_sel_d = result_sel_EX_MEM_i;
            alu_res_d    = alu_res_EX_MEM_i;
            rd_d         = rd_EX_MEM_i;
            pc4_d        = PC_plus_4_EX_MEM_i;
            read_data_d  = ld_done ? ld_ext : '0;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
            inst_q       <= '0;
            reg_write_q  <= 1'b0;
            result_sel_q <= '0;
            alu_res_q    <= '0;
            rd_q         <= '0;
            pc4_q        <= '0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_err_q    <= bus_err_d;
            misalign_q   <= misalign_d;
            inst_q       <= inst_d;
            reg_write_q  <= reg_write_d;
            result_sel_q <= result_sel_d;
            alu_res_q    <= alu_res_d;
            rd_q         <= rd_d;
            pc4_q        <= pc4_d;
            read_data_q  <= read_data_d;
        end
    end

    // Request and stall are combinational, so gate them with reset directly.
    assign dmem.req    = req_c & cpu_rst_n;
    assign mem_stall_o = stall_c & cpu_rst_n;
    assign dmem.we     = is_store;
    assign dmem.addr   = {alu_res_EX_MEM_i[DATA_WIDTH-1:2], 2'b00};
    assign dmem.be     = be;
    assign dmem.wdata  = wdata_lane;

    assign INST_MEM_WB_o       = inst_q;
    assign reg_write_MEM_WB_o  = reg_write_q;
    assign result_sel_MEM_WB_o = result_sel_q;
    assign alu_res_MEM_WB_o    = alu_res_q;
    assign rd_MEM_WB_o         = rd_q;
    assign PC_plus_4_MEM_WB_o  = pc4_q;
    assign read_data_MEM_WB_o  = read_data_q;
    assign misalign_o          = misalign_q;
    assign bus_err_o           = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a transaction-level model predicts
// bus fields, stall cycles and the MEM/WB result of every instruction.
module tb_mem_access_stage;
    logic cpu_clk = 1'b0;
    logic cpu_rst_n = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    dmem_if #(.DATA_WIDTH(32)) dmem ();

    logic [31:0] inst_i, alu_i, wd_i, pc4_i;
    logic        rw_i, mw_i;
    logic [1:0]  rs_i;
    logic [4:0]  rd_i;
    logic [2:0]  f3_i;
    logic [31:0] inst_o, alu_o, pc4_o, rdat_o;
    logic        rw_o, stall_o, mis_o, berr_o;
    logic [1:0]  rs_o;
    logic [4:0]  rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage dut (
        .cpu_clk             (cpu_clk),
        .cpu_rst_n           (cpu_rst_n),
        .INST_EX_MEM_i       (inst_i),
        .reg_write_EX_MEM_i  (rw_i),
        .mem_write_EX_MEM_i  (mw_i),
        .result_sel_EX_MEM_i (rs_i),
        .alu_res_EX_MEM_i    (alu_i),
        .rd_EX_MEM_i         (rd_i),
        .write_data_EX_MEM_i (wd_i),
        .PC_plus_4_EX_MEM_i  (pc4_i),
        .funct3_EX_MEM_i     (f3_i),
        .dmem                (dmem),
        .mem_stall_o         (stall_o),
        .INST_MEM_WB_o       (inst_o),
        .reg_write_MEM_WB_o  (rw_o),
        .result_sel_MEM_WB_o (rs_o),
        .alu_res_MEM_WB_o    (alu_o),
        .rd_MEM_WB_o         (rd_o),
        .PC_plus_4_MEM_WB_o  (pc4_o),
        .read_data_MEM_WB_o  (rdat_o),
        .misalign_o          (mis_o),
        .bus_err_o           (berr_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic store, input logic [2:0] f3);
        if (store) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int sz = acc_size(1'b0, f3);
        logic [31:0] v, mask;
        if (sz == 4) return word;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v = (word >> (8 * addr[1:0])) & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = acc_size(1'b1, f3);
        logic [7:0] m;
        m = 8'(((1 << sz) - 1) << addr[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = acc_size(1'b1, f3);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = d[8*(i % sz) +: 8];
        return o;
    endfunction

    task automatic apply(input logic rw, input logic mw, input logic [1:0] rs, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [2:0] f3, input logic [4:0] rd);
        rw_i = rw; mw_i = mw; rs_i = rs; alu_i = alu; wd_i = wd; f3_i = f3; rd_i = rd;
        inst_i = $urandom; pc4_i = $urandom;
    endtask

    // Runs the currently applied instruction to completion; gd = cycles before
    // gnt, rdl = extra cycles after gnt+1 before rvalid.
    task automatic run_txn(input int gd, input int rdl, input logic [31:0] rword, input string name);
        logic acc, st, mis, done, phase;
        int   sz, wcnt, cyc;
        logic [31:0] e_inst, e_alu, e_pc4, e_rd;
        acc = mw_i | (rs_i == 2'b01);
        st  = mw_i;
        sz  = acc_size(st, f3_i);
        mis = acc && ((alu_i % sz) != 0);
        e_inst = inst_i; e_alu = alu_i; e_pc4 = pc4_i; e_rd = 32'(rd_i);
        $display("[TB] txn %s acc=%0b st=%0b f3=%0d addr=%08h gd=%0d rdl=%0d", name, acc, st, f3_i, alu_i, gd, rdl);
        if (!acc || mis) begin
            @(negedge cpu_clk);
            check({name, " req"}, dmem.req, 1'b0);
            check({name, " stall"}, stall_o, 1'b0);
            @(posedge cpu_clk); #1;
            check({name, " misalign"}, mis_o, mis);
            check({name, " rw"}, rw_o, mis ? 1'b0 : rw_i);
            check({name, " inst"}, inst_o, mis ? 32'h0 : e_inst);
            check({name, " alu"}, alu_o, mis ? 32'h0 : e_alu);
            check({name, " rd"}, rd_o, mis ? 32'h0 : e_rd);
        end else begin
            phase = 1'b0; wcnt = 0; cyc = 0; done = 1'b0;
            while (!done && cyc < 40) begin
                dmem.gnt    = !phase && (wcnt == gd);
                dmem.rvalid = phase && (wcnt == rdl);
                dmem.rdata  = dmem.rvalid ? rword : $urandom;
                @(negedge cpu_clk);
                check({name, " req"}, dmem.req, !phase);
                if (!phase && dmem.gnt) begin
                    check({name, " we"}, dmem.we, st);
                    check({name, " addr"}, dmem.addr, {alu_i[31:2], 2'b00});
                    if (st) begin
                        check({name, " be"}, dmem.be, ref_be(f3_i, alu_i));
                        check({name, " wdata"}, dmem.wdata, ref_wdata(f3_i, wd_i));
                    end
                end
                check({name, " stall"}, stall_o,
                      !((!phase && dmem.gnt && st) || (phase && dmem.rvalid)));
                @(posedge cpu_clk); #1;
                if (!phase && dmem.gnt) begin
                    if (st) done = 1'b1;
                    else begin phase = 1'b1; wcnt = 0; end
                end else if (phase && dmem.rvalid) begin
                    done = 1'b1;
                end else begin
                    wcnt++;
                end
                if (!done) check({name, " bubble"}, rw_o, 1'b0);
                dmem.gnt = 1'b0; dmem.rvalid = 1'b0;
                cyc++;
            end
            check({name, " completed"}, done, 1'b1);
            check({name, " rw"}, rw_o, rw_i);
            check({name, " inst"}, inst_o, e_inst);
            check({name, " pc4"}, pc4_o, e_pc4);
            check({name, " rs"}, rs_o, rs_i);
            if (!st) check({name, " rdata"}, rdat_o, ref_load(f3_i, alu_i, rword));
            check({name, " misalign"}, mis_o, 1'b0);
        end
        check({name, " bus_err"}, berr_o, 1'b0);
    endtask

    int n_st;
    logic got_rel;

    initial begin
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
        apply(1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 3'b010, 5'd3);
        @(posedge cpu_clk); #1;
        check("rst req", dmem.req, 1'b0);
        check("rst stall", stall_o, 1'b0);
        check("rst rw", rw_o, 1'b0);
        check("rst inst", inst_o, 32'h0);
        check("rst rdata", rdat_o, 32'h0);
        check("rst misalign", mis_o, 1'b0);
        check("rst bus_err", berr_o, 1'b0);
        apply(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 3'b000, 5'd0);
        @(posedge cpu_clk); #1;
        cpu_rst_n = 1'b1;

        apply(1'b1, 1'b0, 2'b00, 32'h1234, 32'h0, 3'b000, 5'd5);
        run_txn(0, 0, 32'h0, "alu");
        check("alu value", alu_o, 32'h1234);
        apply(1'b0, 1'b1, 2'b00, 32'h103, 32'hAB, 3'b000, 5'd0);
        run_txn(0, 0, 32'h0, "sb");
        apply(1'b1, 1'b0, 2'b01, 32'h101, 32'h0, 3'b000, 5'd9);
        run_txn(0, 2, 32'h0000_80FF, "lb");
        check("lb value", rdat_o, 32'hFFFF_FF80);
        apply(1'b1, 1'b0, 2'b01, 32'h101, 32'h0, 3'b100, 5'd9);
        run_txn(0, 2, 32'h0000_80FF, "lbu");
        check("lbu value", rdat_o, 32'h0000_0080);
        apply(1'b1, 1'b0, 2'b01, 32'h202, 32'h0, 3'b010, 5'd4);
        run_txn(0, 0, 32'h0, "lw_mis");

        for (int t = 0; t < 150; t++) begin
            int kind, sz;
            logic [31:0] a;
            logic [2:0] f3;
            kind = $urandom_range(0, 3);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if (kind == 0) begin
                apply(1'($urandom), 1'b0, $urandom_range(0, 1) ? 2'b10 : 2'b00, a, $urandom, f3, 5'($urandom));
            end else if (kind == 1) begin
                sz = acc_size(1'b1, f3);
                if ($urandom_range(0, 9) < 7) a = a & ~32'(sz - 1);
                apply(1'b0, 1'b1, 2'b00, a, $urandom, f3, 5'($urandom));
            end else begin
                sz = acc_size(1'b0, f3);
                if ($urandom_range(0, 9) < 7) a = a & ~32'(sz - 1);
                apply(1'($urandom), 1'b0, 2'b01, a, $urandom, f3, 5'($urandom));
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, "rnd");
        end

        apply(1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 3'b010, 5'd6);
        $display("[TB] txn timeout load addr=00000300");
        n_st = 0; got_rel = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge cpu_clk);
            if (stall_o) n_st++;
            else begin got_rel = 1'b1; break; end
        end
        check("to released", got_rel, 1'b1);
        check("to stall cycles", 32'(n_st), 32'd255);
        check("to bus_err", berr_o, 1'b1);
        @(posedge cpu_clk); #1;
        check("to bubble", rw_o, 1'b0);
        apply(1'b1, 1'b0, 2'b00, 32'h77, 32'h0, 3'b000, 5'd2);
        @(posedge cpu_clk); #1;
        check("to sticky", berr_o, 1'b1);
        cpu_rst_n = 1'b0; #1;
        check("to rst clears", berr_o, 1'b0);
        @(posedge cpu_clk); #1;
        cpu_rst_n = 1'b1;

        apply(1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 3'b010, 5'd8);
        $display("[TB] txn reset-in-wait load addr=00000400");
        dmem.gnt = 1'b1;
        @(negedge cpu_clk);
        check("mid req", dmem.req, 1'b1);
        @(posedge cpu_clk); #1;
        dmem.gnt = 1'b0;
        @(negedge cpu_clk);
        check("mid wait stall", stall_o, 1'b1);
        #2 cpu_rst_n = 1'b0; #1;
        check("mid rst req", dmem.req, 1'b0);
        check("mid rst stall", stall_o, 1'b0);
        check("mid rst rw", rw_o, 1'b0);
        apply(1'b1, 1'b0, 2'b00, 32'h55, 32'h0, 3'b000, 5'd7);
        @(posedge cpu_clk); #1;
        cpu_rst_n = 1'b1;
        dmem.rvalid = 1'b1; dmem.rdata = 32'hDEAD_BEEF;
        @(negedge cpu_clk);
        check("stray stall", stall_o, 1'b0);
        @(posedge cpu_clk); #1;
        dmem.rvalid = 1'b0;
        check("stray rdata", rdat_o, 32'h0);
        check("stray rd", rd_o, 5'd7);
        check("stray alu", alu_o, 32'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
